// File: rtl/jtag_tap.sv
// jtag_tap: IEEE 1149.1 test access port.
// 16-state TAP controller, instruction register, BYPASS and IDCODE data
// registers, user scan-chain selection/strobes and negedge-registered TDO.
module jtag_tap #(
    parameter int unsigned          IR_WIDTH      = 4,
    parameter logic [31:0]          IDCODE_VALUE  = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0]  IDCODE_OPCODE = IR_WIDTH'(1),
    parameter int unsigned          NUM_USER      = 2,
    parameter logic [IR_WIDTH-1:0]  USER_BASE     = IR_WIDTH'(8)
) (
    input  logic                tck,
    input  logic                trst,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    output logic [3:0]          state,
    output logic [IR_WIDTH-1:0] ir,
    output logic [NUM_USER-1:0] user_sel,
    output logic                user_capture,
    output logic                user_shift,
    output logic                user_update,
    input  logic [NUM_USER-1:0] user_tdo
);

    typedef enum logic [3:0] {
        EXIT2_DR   = 4'h0,
        EXIT1_DR   = 4'h1,
        SHIFT_DR   = 4'h2,
        PAUSE_DR   = 4'h3,
        SELECT_IR  = 4'h4,
        UPDATE_DR  = 4'h5,
        CAPTURE_DR = 4'h6,
        SELECT_DR  = 4'h7,
        EXIT2_IR   = 4'h8,
        EXIT1_IR   = 4'h9,
        SHIFT_IR   = 4'hA,
        PAUSE_IR   = 4'hB,
        RTI        = 4'hC,
        UPDATE_IR  = 4'hD,
        CAPTURE_IR = 4'hE,
        TLR        = 4'hF
    } tap_state_t;

    // Value loaded into the IR shifter on CAPTURE_IR: ...0001 (LSBs "01").
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

    tap_state_t          state_reg;
    tap_state_t          state_next;
    logic [IR_WIDTH-1:0] ir_reg;
    logic [IR_WIDTH-1:0] ir_shift_reg;
    logic                bypass_reg;
    logic [31:0]         idcode_reg;
    logic                tdo_reg;
    logic                tdo_en_reg;

    logic [NUM_USER-1:0] user_hit;
    logic                sel_idcode;
    logic                sel_user;
    logic                user_dr_tdo;
    logic                tdo_src;
    logic                in_shift;

    // Standard 1149.1 state graph, driven by tms.
    always_comb begin
        state_next = TLR;
        case (state_reg)
            TLR:        state_next = tms ? TLR       : RTI;
            RTI:        state_next = tms ? SELECT_DR : RTI;
            SELECT_DR:  state_next = tms ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR: state_next = tms ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:   state_next = tms ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:   state_next = tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:   state_next = tms ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:   state_next = tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:  state_next = tms ? SELECT_DR : RTI;
            SELECT_IR:  state_next = tms ? TLR       : CAPTURE_IR;
            CAPTURE_IR: state_next = tms ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:   state_next = tms ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:   state_next = tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:   state_next = tms ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:   state_next = tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:  state_next = tms ? SELECT_DR : RTI;
            default:    state_next = TLR;
        endcase
    end

    // TAP controller state register.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_reg <= TLR;
        end else begin
            state_reg <= state_next;
        end
    end

    // Instruction shifter and active instruction; ir only changes on
    // leaving UPDATE_IR or when heading into TLR, so an abandoned scan
    // never leaks into it.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            ir_shift_reg <= '0;
            ir_reg       <= IDCODE_OPCODE;
        end else begin
            if (state_reg == CAPTURE_IR) begin
                ir_shift_reg <= IR_CAPTURE;
            end else if (state_reg == SHIFT_IR) begin
                ir_shift_reg <= {tdi, ir_shift_reg[IR_WIDTH-1:1]};
            end
            if (state_reg == UPDATE_IR) begin
                ir_reg <= ir_shift_reg;
            end else if (state_next == TLR) begin
                ir_reg <= IDCODE_OPCODE;
            end
        end
    end

    // Per-chain opcode match; chain gi answers to USER_BASE+gi.
    generate
        for (genvar gi = 0; gi < int'(NUM_USER); gi++) begin : g_user_dec
            localparam logic [IR_WIDTH-1:0] USER_OP = IR_WIDTH'(int'(USER_BASE) + gi);
            assign user_hit[gi] = (ir_reg == USER_OP);
        end
    endgenerate

    // IDCODE takes precedence should its opcode ever overlap a user opcode.
    assign sel_idcode   = (ir_reg == IDCODE_OPCODE);
    assign user_sel     = sel_idcode ? '0 : user_hit;
    assign sel_user     = |user_sel;
    assign user_dr_tdo  = |(user_sel & user_tdo);

    assign user_capture = (state_reg == CAPTURE_DR) && sel_user;
    assign user_shift   = (state_reg == SHIFT_DR)   && sel_user;
    assign user_update  = (state_reg == UPDATE_DR)  && sel_user;

    // Internal data registers: only the selected one captures or shifts.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            bypass_reg <= 1'b0;
            idcode_reg <= IDCODE_VALUE;
        end else if (sel_idcode) begin
            if (state_reg == CAPTURE_DR) begin
                idcode_reg <= IDCODE_VALUE;
            end else if (state_reg == SHIFT_DR) begin
                idcode_reg <= {tdi, idcode_reg[31:1]};
            end
        end else if (!sel_user) begin
            if (state_reg == CAPTURE_DR) begin
                bypass_reg <= 1'b0;
            end else if (state_reg == SHIFT_DR) begin
                bypass_reg <= tdi;
            end
        end
    end

    // TDO source: IR shifter LSB or the selected DR's serial output.
    always_comb begin
        tdo_src  = 1'b0;
        in_shift = 1'b0;
        if (state_reg == SHIFT_IR) begin
            tdo_src  = ir_shift_reg[0];
            in_shift = 1'b1;
        end else if (state_reg == SHIFT_DR) begin
            in_shift = 1'b1;
            if (sel_idcode) begin
                tdo_src = idcode_reg[0];
            end else if (sel_user) begin
                tdo_src = user_dr_tdo;
            end else begin
                tdo_src = bypass_reg;
            end
        end
    end

    // TDO and its enable are retimed to the falling edge of tck.
    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            tdo_reg    <= 1'b0;
            tdo_en_reg <= 1'b0;
        end else begin
            tdo_reg    <= tdo_src;
            tdo_en_reg <= in_shift;
        end
    end

    assign tdo    = tdo_reg;
    assign tdo_en = tdo_en_reg;
    assign state  = state_reg;
    assign ir     = ir_reg;

endmodule

// File: tb/tb_jtag_tap.sv
// tb_jtag_tap: directed scans through the TAP; expected TDO bits are queued
// by the stimulus and popped by a falling-edge monitor while tdo_en is high.
module tb_jtag_tap;

    logic       tck;
    logic       trst;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_en;
    logic [3:0] state;
    logic [3:0] ir;
    logic [1:0] user_sel;
    logic       user_capture;
    logic       user_shift;
    logic       user_update;
    logic [1:0] user_tdo;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_bit   = 0;
    logic        exp_q[$];

    localparam logic [31:0] IDCODE = 32'h1000_0001;
    localparam logic [31:0] PAT    = 32'hA5C3_1E69;

    jtag_tap dut (
        .tck          (tck),
        .trst         (trst),
        .tms          (tms),
        .tdi          (tdi),
        .tdo          (tdo),
        .tdo_en       (tdo_en),
        .state        (state),
        .ir           (ir),
        .user_sel     (user_sel),
        .user_capture (user_capture),
        .user_shift   (user_shift),
        .user_update  (user_update),
        .user_tdo     (user_tdo)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One tck cycle: drive tms/tdi just after the rising edge.
    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge tck);
        #1;
    endtask

    // n shift cycles; each queues the TDO bit expected during that cycle.
    task automatic shift_bits(input int n, input logic [63:0] din,
                              input logic [63:0] exp, input bit exit_last);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp[i]);
            step(exit_last && (i == n - 1), din[i]);
        end
    endtask

    task automatic dr_enter();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic dr_leave();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // Full IR scan from RTI back to RTI; captured pattern reads out 1,0,0,0.
    task automatic ir_scan(input logic [3:0] op);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        shift_bits(4, {60'd0, op}, 64'h1, 1'b1);
        step(1'b1, 1'b0);
        check("state_update_ir", {28'd0, state}, 32'hD);
        step(1'b0, 1'b0);
        $display("ir scan op=%0h ir=%0h user_sel=%b", op, ir, user_sel);
    endtask

    // Monitor: compare every TDO bit the DUT presents against the queue.
    initial begin
        forever begin
            @(negedge tck);
            #1;
            if (tdo_en) begin
                if (exp_q.size() == 0) begin
                    check("tdo_unexpected", 32'd1, 32'd0);
                end else begin
                    logic e;
                    e = exp_q.pop_front();
                    check($sformatf("tdo_bit%0d", n_bit), {31'd0, tdo}, {31'd0, e});
                    n_bit++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        trst     = 1'b1;
        tms      = 1'b1;
        tdi      = 1'b0;
        user_tdo = 2'b00;
        #12;
        check("reset_state",    {28'd0, state}, 32'hF);
        check("reset_ir",       {28'd0, ir}, 32'h1);
        check("reset_tdo",      {31'd0, tdo}, 32'd0);
        check("reset_tdo_en",   {31'd0, tdo_en}, 32'd0);
        check("reset_user_sel", {30'd0, user_sel}, 32'd0);
        @(posedge tck);
        #1;
        trst = 1'b0;

        // IDCODE straight after reset, then tdi delayed by 32.
        step(1'b0, 1'b0);
        check("state_rti", {28'd0, state}, 32'hC);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("state_capture_dr", {28'd0, state}, 32'h6);
        step(1'b0, 1'b0);
        check("state_shift_dr", {28'd0, state}, 32'h2);
        shift_bits(32, {32'd0, PAT}, {32'd0, IDCODE}, 1'b0);
        shift_bits(8, 64'd0, {56'd0, PAT[7:0]}, 1'b1);
        check("state_exit1_dr", {28'd0, state}, 32'h1);
        dr_leave();
        $display("idcode scan done, bits checked so far=%0d", n_bit);

        // trst in the middle of SHIFT_DR.
        dr_enter();
        shift_bits(3, 64'd0, 64'h1, 1'b0);
        trst = 1'b1;
        #2;
        check("midrst_state",  {28'd0, state}, 32'hF);
        check("midrst_tdo",    {31'd0, tdo}, 32'd0);
        check("midrst_tdo_en", {31'd0, tdo_en}, 32'd0);
        check("midrst_ir",     {28'd0, ir}, 32'h1);
        trst = 1'b0;
        step(1'b0, 1'b0);
        $display("mid-shift reset done, state=%0h", state);

        // Opcode F -> BYPASS: 0 then tdi delayed by one.
        ir_scan(4'hF);
        check("ir_after_F", {28'd0, ir}, 32'hF);
        dr_enter();
        shift_bits(6, 64'b101101, 64'b011010, 1'b1);
        dr_leave();

        // Unknown opcode 5 behaves as BYPASS.
        ir_scan(4'h5);
        check("ir_after_5",       {28'd0, ir}, 32'h5);
        check("user_sel_after_5", {30'd0, user_sel}, 32'd0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("op5_no_user_capture", {31'd0, user_capture}, 32'd0);
        step(1'b0, 1'b0);
        shift_bits(6, 64'b110010, 64'b100100, 1'b1);
        dr_leave();

        // User chain 1 via opcode 9.
        ir_scan(4'h9);
        check("ir_after_9",       {28'd0, ir}, 32'h9);
        check("user_sel_after_9", {30'd0, user_sel}, 32'h2);
        step(1'b1, 1'b0);
        check("user_capture_sel_dr", {31'd0, user_capture}, 32'd0);
        step(1'b0, 1'b0);
        check("user_capture_cap", {31'd0, user_capture}, 32'd1);
        check("user_shift_cap",   {31'd0, user_shift}, 32'd0);
        step(1'b0, 1'b0);
        check("user_capture_shift", {31'd0, user_capture}, 32'd0);
        begin
            logic [3:0] upat;
            upat = 4'b0110;
            for (int i = 0; i < 4; i++) begin
                user_tdo = {upat[i], ~upat[i]};
                check($sformatf("user_shift_cyc%0d", i), {31'd0, user_shift}, 32'd1);
                exp_q.push_back(upat[i]);
                step(i == 3, 1'b0);
            end
        end
        check("user_shift_exit1", {31'd0, user_shift}, 32'd0);
        step(1'b1, 1'b0);
        check("user_update_upd", {31'd0, user_update}, 32'd1);
        step(1'b0, 1'b0);
        check("user_update_rti", {31'd0, user_update}, 32'd0);
        user_tdo = 2'b00;

        // Five tms=1 from RTI reach TLR and restore IDCODE.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("tlr_state",    {28'd0, state}, 32'hF);
        check("tlr_ir",       {28'd0, ir}, 32'h1);
        check("tlr_user_sel", {30'd0, user_sel}, 32'd0);
        step(1'b0, 1'b0);

        // Pause in the middle of an IDCODE scan.
        dr_enter();
        shift_bits(16, 64'd0, 64'h0001, 1'b1);
        step(1'b0, 1'b0);
        check("state_pause_dr", {28'd0, state}, 32'h3);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("state_exit2_dr", {28'd0, state}, 32'h0);
        step(1'b0, 1'b0);
        shift_bits(16, 64'd0, 64'h1000, 1'b1);
        dr_leave();
        $display("pause scan done, bits checked so far=%0d", n_bit);

        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("tdo_queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
